morse_symbol_decoder: RTL

Downstream stage of the dit/dah classifier. Consumes its one-cycle symbol codes (WAIT, DIT, DAH, GAP, SPACE), accumulates dits and dahs into a Morse element pattern, and translates the pattern to 8-bit ASCII when a GAP or SPACE closes the letter. Decoded characters go into a small output FIFO with a valid/ready handshake toward the display/UART stage.

---
 rtl/morse_symbol_decoder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/morse_symbol_decoder.sv
// Morse symbol decoder: accumulates DIT/DAH symbols into a pattern and pushes the decoded ASCII
// character into a small valid/ready output FIFO. Define MORSE_DIGITS_EN to decode 5-element digit patterns.
module morse_symbol_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ditsdahs,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       err_unknown,
  output logic       fifo_ovf
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] SYM_DIT   = 3'd1;
  localparam logic [2:0] SYM_DAH   = 3'd2;
  localparam logic [2:0] SYM_GAP   = 3'd3;
  localparam logic [2:0] SYM_SPACE = 3'd4;

  typedef enum logic [1:0] {EMPTY, ACCUM, SPACE_PEND} state_t;

  state_t      state, state_next;
  logic [4:0]  code, code_next;
  logic [2:0]  len, len_next;
  logic        too_long, too_long_next;
  logic        last_space;
  logic        push, push_ok, pop, full;
  logic [7:0]  push_data, lut_char;
  logic        err_next, is_elem, elem_bit;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;

  // Bits above len are always zero, so {len, code} is a unique key per pattern.
  always_comb begin
    lut_char = "?";
    if (!too_long) begin
      case ({len, code})
        {3'd1, 5'd0}:  lut_char = "E";
        {3'd1, 5'd1}:  lut_char = "T";
        {3'd2, 5'd0}:  lut_char = "I";
        {3'd2, 5'd1}:  lut_char = "N";
        {3'd2, 5'd2}:  lut_char = "A";
        {3'd2, 5'd3}:  lut_char = "M";
        {3'd3, 5'd0}:  lut_char = "S";
        {3'd3, 5'd1}:  lut_char = "D";
        {3'd3, 5'd2}:  lut_char = "R";
        {3'd3, 5'd3}:  lut_char = "G";
        {3'd3, 5'd4}:  lut_char = "U";
        {3'd3, 5'd5}:  lut_char = "K";
        {3'd3, 5'd6}:  lut_char = "W";
        {3'd3, 5'd7}:  lut_char = "O";
        {3'd4, 5'd0}:  lut_char = "H";
        {3'd4, 5'd1}:  lut_char = "B";
        {3'd4, 5'd2}:  lut_char = "L";
        {3'd4, 5'd3}:  lut_char = "Z";
        {3'd4, 5'd4}:  lut_char = "F";
        {3'd4, 5'd5}:  lut_char = "C";
        {3'd4, 5'd6}:  lut_char = "P";
        {3'd4, 5'd8}:  lut_char = "V";
        {3'd4, 5'd9}:  lut_char = "X";
        {3'd4, 5'd11}: lut_char = "Q";
        {3'd4, 5'd13}: lut_char = "Y";
        {3'd4, 5'd14}: lut_char = "J";
`ifdef MORSE_DIGITS_EN
        {3'd5, 5'd31}: lut_char = "0";
        {3'd5, 5'd30}: lut_char = "1";
        {3'd5, 5'd28}: lut_char = "2";
        {3'd5, 5'd24}: lut_char = "3";
        {3'd5, 5'd16}: lut_char = "4";
        {3'd5, 5'd0}:  lut_char = "5";
        {3'd5, 5'd1}:  lut_char = "6";
        {3'd5, 5'd3}:  lut_char = "7";
        {3'd5, 5'd7}:  lut_char = "8";
        {3'd5, 5'd15}: lut_char = "9";
`endif
        default:       lut_char = "?";
      endcase
    end
  end

  assign is_elem  = (ditsdahs == SYM_DIT) || (ditsdahs == SYM_DAH);
  assign elem_bit = (ditsdahs == SYM_DAH);

  always_comb begin
    state_next    = state;
    code_next     = code;
    len_next      = len;
    too_long_next = too_long;
    push          = 1'b0;
    push_data     = lut_char;
    err_next      = 1'b0;
    case (state)
      EMPTY: begin
        if (is_elem) begin
          code_next[0] = elem_bit;
          len_next     = 3'd1;
          state_next   = ACCUM;
        end else if (ditsdahs == SYM_SPACE && !last_space) begin
          push      = 1'b1;
          push_data = 8'h20;
        end
      end
      ACCUM: begin
        if (is_elem) begin
          if (len < 3'd5) begin
            for (int unsigned i = 0; i < 5; i++)
              if (32'(len) == i) code_next[i] = elem_bit;
            len_next = len + 3'd1;
          end else begin
            too_long_next = 1'b1;
          end
        end else if (ditsdahs == SYM_GAP || ditsdahs == SYM_SPACE) begin
          push          = 1'b1;
          err_next      = (lut_char == "?");
          code_next     = '0;
          len_next      = '0;
          too_long_next = 1'b0;
          state_next    = (ditsdahs == SYM_SPACE) ? SPACE_PEND : EMPTY;
        end
      end
      SPACE_PEND: begin
        // Accumulator is already clear here, so a new element starts at bit 0.
        push       = 1'b1;
        push_data  = 8'h20;
        state_next = EMPTY;
        if (is_elem) begin
          code_next[0] = elem_bit;
          len_next     = 3'd1;
          state_next   = ACCUM;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  assign char_valid = (count != '0);
  assign char_data  = char_valid ? mem[rd_ptr] : '0;
  assign full       = (count == DEPTH_CNT);
  assign pop        = char_valid && char_ready;
  assign push_ok    = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      code        <= '0;
      len         <= '0;
      too_long    <= 1'b0;
      last_space  <= 1'b0;
      err_unknown <= 1'b0;
      fifo_ovf    <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      state       <= state_next;
      code        <= code_next;
      len         <= len_next;
      too_long    <= too_long_next;
      err_unknown <= err_next;
      if (push && !push_ok) fifo_ovf <= 1'b1;
      if (push_ok) begin
        last_space <= (push_data == 8'h20);
        wr_ptr     <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + (AW+1)'(1);
      else if (!push_ok && pop) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule
